sum_fifo_clk: RTL
=================

SUM_FIFO_CLK -- requirements
Module: sum_fifo_clk

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entry count; power of two, at least 2.
REQ-002 SHALL have parameter CNT_W, default 16, width of the statistics counters.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the adder result on s_in/co_in is valid this cycle.
REQ-006 SHALL have port s_in, input, 32 bits: registered sum from the upstream clocked adder.
REQ-007 SHALL have port co_in, input, 1 bit: registered carry-out from the upstream adder.
REQ-008 SHALL have port out_ready, input, 1 bit: the consumer accepts out_data this cycle.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data holds the oldest stored entry.
REQ-010 SHALL have port out_data, output, 33 bits: {co, s} of the head entry.
REQ-011 SHALL have port full, output, 1 bit: asserted while count equals DEPTH.
REQ-012 SHALL have port empty, output, 1 bit: asserted while count equals 0.
REQ-013 SHALL have port count, output, log2(DEPTH)+1 bits: number of stored entries.
REQ-014 SHALL have port ovf_cnt, output, CNT_W bits: number of accepted entries with co=1.
REQ-015 SHALL have port drop_cnt, output, CNT_W bits: number of in_valid cycles rejected.

Function
REQ-016 SHALL define pop as out_valid && out_ready.
REQ-017 SHALL define push as in_valid && (!full || pop), so a push into a full FIFO is accepted when a pop occurs in the same cycle.
REQ-018 SHALL write {co_in, s_in} to mem[wr_ptr] on push, then advance wr_ptr modulo DEPTH.
REQ-019 SHALL advance rd_ptr modulo DEPTH on pop.
REQ-020 SHALL operate first-word-fall-through: out_valid = !empty and out_data = mem[rd_ptr], with no read latency.
REQ-021 SHALL make an entry pushed at edge N visible on out_valid/out_data immediately after edge N.
REQ-022 SHALL update count as follows: +1 on push only, -1 on pop only, unchanged on push and pop together.
REQ-023 SHALL, when empty, never pop, so a simultaneous push sets count to 1.
REQ-024 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-025 SHALL increment drop_cnt once per cycle with in_valid && full && !pop; the FIFO contents stay unchanged.
REQ-026 SHALL increment ovf_cnt once per push with co_in=1.
REQ-027 SHALL saturate both counters at all-ones, never wrapping to 0.
REQ-028 SHALL produce full and empty as registered flags, consistent with count on every cycle.

Reset
REQ-029 SHALL, while reset_n=0, clear without waiting for clk: pointers, count, ovf_cnt, drop_cnt and out_valid to 0, empty to 1, full to 0.
REQ-030 SHALL drive out_data to 33'h0 in reset; memory contents need not be cleared.
REQ-031 SHALL discard all stored entries on a mid-operation reset; the first post-reset push appears as the sole entry.
REQ-032 SHALL accept the first push on the first rising edge after reset_n deasserts.

Structure
REQ-033 SHALL place SUM_W=32, ENTRY_W=33, DEPTH default and CNT_W default as constants in shared package add_pkg.
REQ-034 SHALL implement both statistics counters by instantiating one sub-module, sat_cnt (parameter CNT_W; ports clk, reset_n, inc, value), twice.
REQ-035 SHALL contain no combinational path from in_valid to out_valid.

Verification
REQ-036 SHALL cover single pass: push s=32'd164922, co=0; then out_ready=1 -> out_data=33'h0_0002_843A on the cycle after the push, then empty=1.
REQ-037 SHALL cover fill and overflow: with out_ready=0, push 5 entries at DEPTH=4 -> full=1, count=4, drop_cnt=1, first 4 entries read back in order.
REQ-038 SHALL cover full with simultaneous push and pop: count stays 4, drop_cnt unchanged, new entry emerges 4th.
REQ-039 SHALL cover carry accounting: push {co=1, s=0} (from 32'hFFFFFFFF+1) three times -> ovf_cnt=3; preload ovf_cnt near saturation -> value holds at 16'hFFFF.
REQ-040 SHALL cover pointer wrap-around: 10 interleaved push/pop pairs -> data order preserved across wrap.
REQ-041 SHALL cover asynchronous reset: assert reset_n=0 mid-cycle with 3 entries stored -> empty=1 and count=0 immediately, counters 0.

Source files
------------

// File: rtl/add_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : add_pkg
//  Description : Shared widths, defaults and entry layout for the adder-result
//                FIFO and its statistics counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package add_pkg;

    // Width of the upstream adder sum
    localparam int SUM_W         = 32;
    // One FIFO entry holds {carry, sum}
    localparam int ENTRY_W       = SUM_W + 1;
    // Default FIFO depth (power of two, at least 2)
    localparam int DEPTH_DEFAULT = 4;
    // Default width of the saturating statistics counters
    localparam int CNT_W_DEFAULT = 16;

    // Field view of a stored entry; carry sits in the MSB
    typedef struct packed {
        logic             co;
        logic [SUM_W-1:0] s;
    } entry_t;

    // Pack a carry and a sum into the stored entry layout
    function automatic logic [ENTRY_W-1:0] pack_entry(input logic co,
                                                      input logic [SUM_W-1:0] s);
        entry_t e;
        e.co = co;
        e.s  = s;
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : sat_cnt
//  Description : Event counter that increments by one per enabled cycle and
//                sticks at all-ones instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    output logic [CNT_W-1:0] value
);

    logic [CNT_W-1:0] r_value;
    logic             w_at_max;

    assign w_at_max = &r_value;

    // Count enabled cycles, holding once the maximum is reached
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_value <= '0;
        end else if (inc && !w_at_max) begin
            r_value <= r_value + 1'b1;
        end
    end

    assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/sum_fifo_clk.sv
`default_nettype none
// ============================================================================
//  Module      : sum_fifo_clk
//  Description : First-word-fall-through FIFO buffering {carry, sum} results
//                of an upstream clocked adder, with saturating counts of
//                carry-out entries and rejected writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module sum_fifo_clk
    import add_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    input  logic [SUM_W-1:0]       s_in,
    input  logic                   co_in,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [ENTRY_W-1:0]     out_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [CNT_W-1:0]       ovf_cnt,
    output logic [CNT_W-1:0]       drop_cnt
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0] c_full_cnt = (c_ptr_w + 1)'(DEPTH);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               r_full;
    logic               r_empty;

    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic               w_ovf_inc;
    logic [c_ptr_w:0]   w_count_nxt;

    // Handshake decode: pop only when something is stored, and a full FIFO
    // still takes a write if the head leaves in the same cycle
    assign w_pop     = !r_empty && out_ready;
    assign w_push    = in_valid && (!r_full || w_pop);
    assign w_drop    = in_valid && r_full && !w_pop;
    assign w_ovf_inc = w_push && co_in;

    // Next occupancy; simultaneous push and pop leave it unchanged
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage array; left uninitialised because reads are gated by empty
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= pack_entry(co_in, s_in);
        end
    end

    // Pointers, occupancy and registered full/empty flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_full_cnt);
            r_empty <= (w_count_nxt == '0);
        end
    end

    // Carry-out entries accepted into the FIFO
    sat_cnt #(
        .CNT_W   (CNT_W)
    ) u_ovf_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (w_ovf_inc),
        .value   (ovf_cnt)
    );

    // Writes turned away because the FIFO was full with no pop
    sat_cnt #(
        .CNT_W   (CNT_W)
    ) u_drop_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (w_drop),
        .value   (drop_cnt)
    );

    // Head entry falls through with no read latency; forced to zero while
    // empty so reset and idle states present a clean bus
    assign out_valid = !r_empty;
    assign out_data  = r_empty ? '0 : r_mem[r_rd_ptr];
    assign full      = r_full;
    assign empty     = r_empty;
    assign count     = r_count;

endmodule
`default_nettype wire
